// File: rtl/clk_cal_disp_ctrl.sv
// Mode/display controller: rotates time/date/year on the shared 4-digit display and turns
// the mode/up/down buttons into single-cycle hour/minute adjust pulses with hold-to-repeat.
`timescale 1ns/1ps
module clk_cal_disp_ctrl #(
    parameter int unsigned T_TIME    = 10,
    parameter int unsigned T_DATE    = 3,
    parameter int unsigned T_YEAR    = 3,
    parameter int unsigned TIMEOUT_S = 15,
    parameter int unsigned HOLD_CYC  = 50000000,
    parameter int unsigned RPT_CYC   = 20000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] hr_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] d_10s,
    input  logic [3:0] d_1s,
    input  logic [3:0] m_10s,
    input  logic [3:0] m_1s,
    input  logic [3:0] y_10s,
    input  logic [3:0] y_1s,
    output logic       inc_hour,
    output logic       dec_hour,
    output logic       inc_minute,
    output logic       dec_minute,
    output logic       stop,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       dp,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        StShowTime = 3'd0,
        StShowDate = 3'd1,
        StShowYear = 3'd2,
        StSetHour  = 3'd3,
        StSetMin   = 3'd4
    } state_e;

    localparam logic [7:0]  TimeLast = 8'(T_TIME - 1);
    localparam logic [7:0]  DateLast = 8'(T_DATE - 1);
    localparam logic [7:0]  YearLast = 8'(T_YEAR - 1);
    localparam logic [7:0]  IdleLast = 8'(TIMEOUT_S - 1);
    localparam logic [31:0] HoldCyc  = 32'(HOLD_CYC);
    localparam logic [31:0] RptCyc   = 32'(RPT_CYC);
    localparam logic [3:0]  Blank    = 4'hF;

    state_e      state_q, state_d;
    logic [7:0]  sec_q, sec_d;
    logic [31:0] rpt_q, rpt_d;
    logic        rpt_run_q, rpt_run_d;
    logic        blink_q, blink_d;
    logic        mode_prev_q, up_prev_q, down_prev_q;

    logic        mode_press, up_press, down_press;
    logic        in_set, rpt_due, step_up, step_down;
    logic [7:0]  show_last;
    state_e      show_next;

    logic        inc_hour_d, dec_hour_d, inc_minute_d, dec_minute_d, stop_d, dp_d;
    logic [3:0]  dig3_d, dig2_d, dig1_d, dig0_d;

    assign mode_press = btn_mode & ~mode_prev_q;
    assign up_press   = btn_up & ~up_prev_q;
    assign down_press = btn_down & ~down_prev_q;
    assign in_set     = (state_q == StSetHour) || (state_q == StSetMin);
    // rpt_q counts held cycles since the last pulse; first gap is HOLD, later gaps RPT.
    assign rpt_due    = rpt_run_q ? (rpt_q == RptCyc) : (rpt_q == HoldCyc);
    assign mode       = state_q;

    always_comb begin
        show_last = TimeLast;
        show_next = StShowDate;
        case (state_q)
            StShowDate: begin
                show_last = DateLast;
                show_next = StShowYear;
            end
            StShowYear: begin
                show_last = YearLast;
                show_next = StShowTime;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        rpt_d     = 32'd0;
        rpt_run_d = 1'b0;
        blink_d   = blink_q;
        step_up   = 1'b0;
        step_down = 1'b0;
        if (mode_press) begin
            case (state_q)
                StSetHour: state_d = StSetMin;
                StSetMin:  state_d = StShowTime;
                default:   state_d = StSetHour;
            endcase
            sec_d   = 8'd0;
            blink_d = 1'b0;
        end else if (in_set) begin
            if (tick_1Hz) begin
                blink_d = ~blink_q;
            end
            // Only a single held button drives adjusts; both or neither keep the counter at 0.
            if (btn_up ^ btn_down) begin
                if (up_press || down_press || rpt_due) begin
                    step_up   = btn_up;
                    step_down = btn_down;
                    rpt_d     = 32'd1;
                    rpt_run_d = ~(up_press | down_press);
                end else begin
                    rpt_d     = rpt_q + 32'd1;
                    rpt_run_d = rpt_run_q;
                end
            end
            if (up_press || down_press || step_up || step_down) begin
                sec_d = 8'd0;
            end else if (tick_1Hz) begin
                if (sec_q == IdleLast) begin
                    state_d   = StShowTime;
                    sec_d     = 8'd0;
                    blink_d   = 1'b0;
                    rpt_d     = 32'd0;
                    rpt_run_d = 1'b0;
                end else begin
                    sec_d = sec_q + 8'd1;
                end
            end
        end else if (tick_1Hz) begin
            if (sec_q == show_last) begin
                state_d = show_next;
                sec_d   = 8'd0;
                blink_d = 1'b0;
            end else begin
                sec_d   = sec_q + 8'd1;
                blink_d = ~blink_q;
            end
        end
    end

    // Outputs are registered from the next-state view so they line up with mode.
    always_comb begin
        inc_hour_d   = step_up && (state_q == StSetHour);
        dec_hour_d   = step_down && (state_q == StSetHour);
        inc_minute_d = step_up && (state_q == StSetMin);
        dec_minute_d = step_down && (state_q == StSetMin);
        stop_d       = (state_d == StSetHour) || (state_d == StSetMin);
        dig3_d       = hr_10s;
        dig2_d       = hr_1s;
        dig1_d       = min_10s;
        dig0_d       = min_1s;
        dp_d         = 1'b1;
        case (state_d)
            StShowTime: dp_d = ~blink_d;
            StShowDate: begin
                dig3_d = d_10s;
                dig2_d = d_1s;
                dig1_d = m_10s;
                dig0_d = m_1s;
            end
            StShowYear: begin
                dig3_d = 4'd2;
                dig2_d = 4'd0;
                dig1_d = y_10s;
                dig0_d = y_1s;
                dp_d   = 1'b0;
            end
            StSetHour: begin
                if (blink_d) begin
                    dig3_d = Blank;
                    dig2_d = Blank;
                end
            end
            StSetMin: begin
                if (blink_d) begin
                    dig1_d = Blank;
                    dig0_d = Blank;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= StShowTime;
            sec_q       <= 8'd0;
            rpt_q       <= 32'd0;
            rpt_run_q   <= 1'b0;
            blink_q     <= 1'b0;
            mode_prev_q <= 1'b1;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
            inc_hour    <= 1'b0;
            dec_hour    <= 1'b0;
            inc_minute  <= 1'b0;
            dec_minute  <= 1'b0;
            stop        <= 1'b0;
            dig3        <= Blank;
            dig2        <= Blank;
            dig1        <= Blank;
            dig0        <= Blank;
            dp          <= 1'b1;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            rpt_q       <= rpt_d;
            rpt_run_q   <= rpt_run_d;
            blink_q     <= blink_d;
            mode_prev_q <= btn_mode;
            up_prev_q   <= btn_up;
            down_prev_q <= btn_down;
            inc_hour    <= inc_hour_d;
            dec_hour    <= dec_hour_d;
            inc_minute  <= inc_minute_d;
            dec_minute  <= dec_minute_d;
            stop        <= stop_d;
            dig3        <= dig3_d;
            dig2        <= dig2_d;
            dig1        <= dig1_d;
            dig0        <= dig0_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_clk_cal_disp_ctrl.sv
// Bench for clk_cal_disp_ctrl: directed stimulus, a cycle-level behavioural model compared
// every cycle, plus hand-computed literal checks on key points.
`timescale 1ns/1ps
module tb_clk_cal_disp_ctrl;

    localparam int TT   = 10;
    localparam int TD   = 3;
    localparam int TY   = 3;
    localparam int TOUT = 15;
    localparam int HOLD = 10;
    localparam int RPT  = 4;

    logic       clk = 1'b0;
    logic       reset, tick_1Hz, btn_mode, btn_up, btn_down;
    logic [3:0] hr_10s, hr_1s, min_10s, min_1s, d_10s, d_1s, m_10s, m_1s, y_10s, y_1s;
    logic       inc_hour, dec_hour, inc_minute, dec_minute, stop, dp;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic [2:0] mode;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    clk_cal_disp_ctrl #(
        .T_TIME(TT), .T_DATE(TD), .T_YEAR(TY), .TIMEOUT_S(TOUT), .HOLD_CYC(HOLD), .RPT_CYC(RPT)
    ) dut (
        .clk_100MHz(clk), .reset(reset), .tick_1Hz(tick_1Hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
        .d_10s(d_10s), .d_1s(d_1s), .m_10s(m_10s), .m_1s(m_1s), .y_10s(y_10s), .y_1s(y_1s),
        .inc_hour(inc_hour), .dec_hour(dec_hour), .inc_minute(inc_minute),
        .dec_minute(dec_minute), .stop(stop),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0), .dp(dp), .mode(mode)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_state, m_ticks, m_n, m_phase;
    bit         m_hold;
    logic       m_pm, m_pu, m_pd;
    logic       e_ih, e_dh, e_im, e_dm, e_stop, e_dp;
    logic [15:0] e_dig;

    function automatic int dur(input int s);
        return (s == 0) ? TT : (s == 1) ? TD : TY;
    endfunction

    always @(posedge clk) begin
        bit mp, upp, dnp, fire;
        if (reset) begin
            m_state = 0; m_ticks = 0; m_phase = 0; m_hold = 0; m_n = 0;
            m_pm = 1; m_pu = 1; m_pd = 1;
            e_ih = 0; e_dh = 0; e_im = 0; e_dm = 0; e_stop = 0; e_dp = 1;
            e_dig = 16'hFFFF;
        end else begin
            mp = btn_mode && !m_pm;
            upp = btn_up && !m_pu;
            dnp = btn_down && !m_pd;
            m_pm = btn_mode; m_pu = btn_up; m_pd = btn_down;
            fire = 0;
            e_ih = 0; e_dh = 0; e_im = 0; e_dm = 0;
            if (mp) begin
                m_state = (m_state == 3) ? 4 : (m_state == 4) ? 0 : 3;
                m_ticks = 0; m_phase = 0; m_hold = 0;
            end else if (m_state >= 3) begin
                if (btn_up != btn_down) begin
                    m_n = (m_hold && !(upp || dnp)) ? m_n + 1 : 0;
                    m_hold = 1;
                    fire = (m_n == 0) ? (upp || dnp) : (m_n >= HOLD && (m_n - HOLD) % RPT == 0);
                end else begin
                    m_hold = 0;
                end
                if (fire) begin
                    e_ih = btn_up && m_state == 3;
                    e_dh = btn_down && m_state == 3;
                    e_im = btn_up && m_state == 4;
                    e_dm = btn_down && m_state == 4;
                end
                if (tick_1Hz) m_phase ^= 1;
                if (upp || dnp || fire) m_ticks = 0;
                else if (tick_1Hz) begin
                    m_ticks++;
                    if (m_ticks == TOUT) begin
                        m_state = 0; m_ticks = 0; m_phase = 0; m_hold = 0;
                    end
                end
            end else begin
                m_hold = 0;
                if (tick_1Hz) begin
                    m_ticks++;
                    m_phase ^= 1;
                    if (m_ticks == dur(m_state)) begin
                        m_state = (m_state + 1) % 3; m_ticks = 0; m_phase = 0;
                    end
                end
            end
            e_stop = (m_state >= 3);
            e_dp = 1;
            e_dig = {hr_10s, hr_1s, min_10s, min_1s};
            case (m_state)
                0: e_dp = !m_phase;
                1: e_dig = {d_10s, d_1s, m_10s, m_1s};
                2: begin e_dig = {4'd2, 4'd0, y_10s, y_1s}; e_dp = 0; end
                3: if (m_phase) e_dig[15:8] = 8'hFF;
                default: if (m_phase) e_dig[7:0] = 8'hFF;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        started = 1;
    end

    always @(negedge clk) begin
        logic [24:0] act, exp_v;
        if (started) begin
            act   = {mode, stop, inc_hour, dec_hour, inc_minute, dec_minute, dp,
                     dig3, dig2, dig1, dig0};
            exp_v = {3'(m_state), e_stop, e_ih, e_dh, e_im, e_dm, e_dp, e_dig};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got=%h want=%h", $time, act, exp_v);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_1Hz = 1; @(negedge clk);
            tick_1Hz = 0; @(negedge clk);
        end
    endtask

    task automatic press_mode();
        btn_mode = 1; @(negedge clk);
        btn_mode = 0; @(negedge clk);
    endtask

    function automatic int digs();
        return int'({dig3, dig2, dig1, dig0});
    endfunction

    function automatic int npulse();
        return int'(inc_hour) + int'(dec_hour) + int'(inc_minute) + int'(dec_minute);
    endfunction

    initial begin
        int pos[$];
        int exp_pos[6] = '{1, 11, 15, 19, 23, 27};
        int cnt;
        reset = 1; tick_1Hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
        hr_10s = 1; hr_1s = 2; min_10s = 3; min_1s = 4;
        d_10s = 2; d_1s = 5; m_10s = 1; m_1s = 2; y_10s = 2; y_1s = 6;
        repeat (2) @(negedge clk);
        check("reset digits", digs(), 'hFFFF);
        check("reset dp", dp, 1);
        check("reset mode", mode, 0);
        check("reset stop", stop, 0);
        reset = 0;
        @(negedge clk);
        check("time digits", digs(), 'h1234);

        // rotation
        tick(TT - 1);
        check("still time", mode, 0);
        check("time dp blink", dp, 0);
        tick(1);
        check("to date", mode, 1);
        check("date digits", digs(), 'h2512);
        check("model date digits", int'(e_dig), 'h2512);
        check("date dp", dp, 1);
        tick(TD);
        check("to year", mode, 2);
        check("year digits", digs(), 'h2026);
        check("year dp", dp, 0);
        tick(TY);
        check("back to time", mode, 0);

        // single press in SET_HOUR
        press_mode();
        check("set hour", mode, 3);
        check("stop set", stop, 1);
        btn_up = 1; @(negedge clk);
        check("inc_hour latency", inc_hour, 1);
        check("model inc_hour", e_ih, 1);
        check("no inc_minute", inc_minute, 0);
        btn_up = 0;
        cnt = 0;
        repeat (5) begin @(negedge clk); cnt += npulse(); end
        check("single pulse only", cnt, 0);

        // hold-to-repeat in SET_MIN
        press_mode();
        check("set min", mode, 4);
        btn_down = 1;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dec_minute) pos.push_back(i);
            cnt += int'(inc_hour) + int'(dec_hour) + int'(inc_minute);
            if (i == 30) btn_down = 0;
        end
        check("repeat count", pos.size(), 6);
        for (int i = 0; i < 6; i++)
            check("repeat position", (i < pos.size()) ? pos[i] : -1, exp_pos[i]);
        check("repeat other pulses", cnt, 0);

        // simultaneous up/down, then mode+up
        press_mode();
        check("min to time", mode, 0);
        check("stop cleared", stop, 0);
        press_mode();
        btn_up = 1; btn_down = 1;
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += npulse(); end
        btn_up = 0; btn_down = 0;
        @(negedge clk);
        check("up+down no pulse", cnt, 0);
        btn_mode = 1; btn_up = 1;
        @(negedge clk);
        check("mode wins state", mode, 4);
        check("mode wins pulse", npulse(), 0);
        btn_mode = 0; btn_up = 0;
        @(negedge clk);

        // blink and idle timeout in SET_MIN; press coinciding with tick 14
        check("set min visible", digs(), 'h1234);
        tick(1);
        check("set min blank", digs(), 'h12FF);
        tick(12);
        check("before restart", mode, 4);
        tick_1Hz = 1; btn_up = 1; @(negedge clk);
        tick_1Hz = 0; btn_up = 0; @(negedge clk);
        tick(TOUT - 1);
        check("restart held", mode, 4);
        tick(1);
        check("timeout state", mode, 0);
        check("timeout stop", stop, 0);

        // mode held through reset release
        reset = 1; btn_mode = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        check("mode held reset", mode, 0);
        btn_mode = 0;
        @(negedge clk);

        // reset during auto-repeat
        press_mode();
        btn_up = 1;
        cnt = 0;
        repeat (14) begin @(negedge clk); cnt += int'(inc_hour); end
        check("pre-reset pulses", cnt, 2);
        reset = 1;
        @(negedge clk);
        check("reset mid mode", mode, 0);
        check("reset mid stop", stop, 0);
        check("reset mid pulses", npulse(), 0);
        check("reset mid digits", digs(), 'hFFFF);
        reset = 0; btn_up = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_cal_disp_ctrl.md
Name: clk_cal_disp_ctrl

Overview:
- Mode/display controller between the clock-calendar core and the 4-digit 7-segment driver.
- Shares the single 4-digit display among time (HH.MM), date (DD.MM) and year (20YY) by auto-rotation.
- Runs a user set-mode FSM that turns three push-buttons into single-cycle hour/minute increment/decrement pulses, with hold-to-repeat. Holds the core's seconds while setting.
- Sits beside the clock-calendar core; its digit outputs feed the 7-segment control block.

Parameters:
- T_TIME, 10, seconds time is shown per rotation (1..255)
- T_DATE, 3, seconds date is shown per rotation (1..255)
- T_YEAR, 3, seconds year is shown per rotation (1..255)
- TIMEOUT_S, 15, idle seconds in a SET state before returning to SHOW_TIME (1..255)
- HOLD_CYC, 50000000, clk cycles a button must stay held before auto-repeat starts
- RPT_CYC, 20000000, clk cycles between auto-repeat pulses

Ports:
- clk_100MHz input 1 system clock
- reset input 1 synchronous, active-high reset
- tick_1Hz input 1 one-cycle pulse once per second from the core
- btn_mode input 1 debounced, synchronized level, high = pressed
- btn_up input 1 debounced, synchronized level
- btn_down input 1 debounced, synchronized level
- hr_10s, hr_1s, min_10s, min_1s input 4 each, BCD time from the core
- d_10s, d_1s, m_10s, m_1s, y_10s, y_1s input 4 each, BCD date from the core
- inc_hour, dec_hour, inc_minute, dec_minute output 1 each, one-cycle adjust pulses to the core
- stop output 1 high = core seconds frozen
- dig3, dig2, dig1, dig0 output 4 each, BCD to the display (dig3 leftmost); 4'hF = blank
- dp output 1 separator (decimal point) between dig2 and dig1
- mode output 3 current state encoding, for debug and LEDs

Behaviour:
- Single clock domain, clk_100MHz. reset is synchronous and active-high. All outputs are registered.
- State encodings: SHOW_TIME=0, SHOW_DATE=1, SHOW_YEAR=2, SET_HOUR=3, SET_MIN=4.
- Reset values:
  - state SHOW_TIME; all pulses 0; stop 0; dp 1; digits 4'hF; all counters 0; blink phase 0.
  - Button previous-value registers reset to 1, so a button held through reset produces no edge.
- Edge detection: press = btn & ~btn_prev. Outputs and state update one cycle after the edge cycle (latency 1).
- Rotation: a seconds counter increments on tick_1Hz in the SHOW states.
  - SHOW_TIME -> SHOW_DATE when the count reaches T_TIME; then SHOW_DATE -> SHOW_YEAR after T_DATE; then SHOW_YEAR -> SHOW_TIME after T_YEAR.
  - The counter clears on every state change.
- btn_mode press:
  - Any SHOW state -> SET_HOUR; SET_HOUR -> SET_MIN; SET_MIN -> SHOW_TIME.
  - Clears the seconds counter, the repeat counter and the blink phase.
- SET states:
  - stop = 1.
  - A btn_up press emits inc_hour (SET_HOUR) or inc_minute (SET_MIN). A btn_down press emits dec_hour or dec_minute.
  - Hold-to-repeat: after HOLD_CYC continuous cycles held, one pulse is emitted, then one every RPT_CYC cycles while still held. Release clears the repeat counter.
- Idle timeout: the seconds counter counts tick_1Hz and clears on any button press or repeat pulse. Reaching TIMEOUT_S -> SHOW_TIME.
- Buttons in SHOW states: btn_up and btn_down are ignored — no pulses, no effect on rotation.
- Simultaneous events:
  - up and down both active: no pulse, repeat counter held at 0.
  - mode press in the same cycle as up/down: mode wins, no pulse.
  - tick_1Hz coinciding with a press: the press clear wins.
- Display mapping:
  - TIME: hr_10s, hr_1s, min_10s, min_1s, dp toggling on each tick (blinking separator).
  - DATE: d_10s, d_1s, m_10s, m_1s, dp = 1.
  - YEAR: 2, 0, y_10s, y_1s, dp = 0.
  - SET_HOUR/SET_MIN: time layout, dp = 1. The edited field pair is forced to 4'hF while blink phase = 1. Blink phase toggles on tick_1Hz and is 0 on entry, so the field is visible immediately.
- Adjust pulses are never asserted for more than 1 consecutive cycle. At most one of the four is high in any cycle.
- Reset mid-operation (during repeat, or in a SET state): next cycle is the full reset state, stop = 0, no pulse.

Test Plan:
- Reset, then tick_1Hz x10 (T_TIME=10) -> state goes to SHOW_DATE; digits = d_10s, d_1s, m_10s, m_1s; dp = 1. After 3 more ticks -> YEAR shows 2, 0, y_10s, y_1s.
- Mode press, then one 1-cycle btn_up press -> state SET_HOUR, stop = 1, exactly one inc_hour pulse one cycle after the edge; inc_minute stays 0.
- HOLD_CYC=10, RPT_CYC=4: in SET_MIN hold btn_down for 30 cycles -> dec_minute pulses at cycles 10, 14, 18, 22, 26, none after release.
- In SET_HOUR press up and down together for 20 cycles -> zero pulses. Mode and up in the same cycle -> SET_MIN with no pulse.
- In SET_MIN, 15 ticks with no buttons -> SHOW_TIME, stop = 0. A press at tick 14 restarts the count.
- Hold btn_mode through reset release -> no state change. Assert reset during auto-repeat -> next cycle: SHOW_TIME, all pulses 0, digits 4'hF.
